// File: rtl/apb_slv_pkg.sv
// Shared types and width helpers for the APB slave register file.
package apb_slv_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } err_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_STRB_WIDTH = strb_width(DEF_DATA_WIDTH);
  localparam int unsigned DEF_OFF_BITS   = off_bits(DEF_DATA_WIDTH);

endpackage

// File: rtl/apb_slv_regbank.sv
// Word storage with per-byte-lane write enables, synchronous clear and a
// combinational read port.
module apb_slv_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [DATA_WIDTH/8-1:0] wr_lanes,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        for (int b = 0; b < int'(LANES); b++) begin
          if (wr_lanes[b] && (wr_idx == IDX_W'(w))) begin
            mem[w][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slv_regfile.sv
// APB4 slave register file: FSM, error decode and optional wait counter.
// Wait states are built only when APB_SLV_WAIT_STATES_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a setup phase (PSELx=1, PENABLE=0)
// ACCESS | transfer latched; counting wait states, then completing
module apb_slv_regfile
  import apb_slv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned RO_BASE     = 24,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W   = strb_width(DATA_WIDTH);
  localparam int unsigned OFF_BITS = off_bits(DATA_WIDTH);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);

  if ((DATA_WIDTH != 8) && (DATA_WIDTH != 16) && (DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_width
    $error("apb_slv_regfile: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if ((DEPTH * STRB_W) > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("apb_slv_regfile: DEPTH does not fit in the address space");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slv_regfile: WAIT_CYCLES must be 0..15");
  end

  state_e                state;
  logic [ADDR_WIDTH-1:0] idx_in;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  err_e                  err_in;
  err_e                  err_q;
  err_e                  err_sel;
  logic                  wr_sel;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  setup;
  logic                  commit;
  logic [STRB_W-1:0]     wr_lanes;

`ifdef APB_SLV_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  logic [3:0] cnt;
`endif

  assign idx_in = PADDR >> OFF_BITS;
  assign setup  = PSELx && !PENABLE;

  always_comb begin
    err_in = ERR_NONE;
    if (|(PADDR & OFF_MASK)) begin
      err_in = ERR_ALIGN;
    end else if (32'(idx_in) >= DEPTH) begin
      err_in = ERR_RANGE;
    end else if (PWRITE && (32'(idx_in) >= RO_BASE)) begin
      err_in = ERR_RO;
    end
  end

  // In IDLE the response can only be for a zero-wait setup, so look at the
  // live bus; otherwise use the latched transfer.
  assign err_sel = (state == IDLE) ? err_in : err_q;
  assign wr_sel  = (state == IDLE) ? PWRITE : wr_q;

  always_comb begin
    rsp_data = '0;
    if (!wr_sel && (err_sel == ERR_NONE)) begin
      rsp_data = rd_data;
    end
  end

  assign commit   = (state == ACCESS) && PREADY && PSELx && wr_q && (err_q == ERR_NONE);
  assign wr_lanes = strb_q & {STRB_W{commit}};

  apb_slv_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regbank (
    .clk      (PCLK),
    .clr      (PRESET),
    .wr_lanes (wr_lanes),
    .wr_idx   (IDX_W'(idx_q)),
    .wr_data  (wdata_q),
    .rd_idx   (IDX_W'((state == IDLE) ? idx_in : idx_q)),
    .rd_data  (rd_data)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= ERR_NONE;
`ifdef APB_SLV_WAIT_STATES_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
          if (setup) begin
            state   <= ACCESS;
            idx_q   <= idx_in;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= err_in;
`ifdef APB_SLV_WAIT_STATES_EN
            cnt     <= WAIT_LD;
            if (WAIT_LD == 4'd0) begin
              PREADY  <= 1'b1;
              PSLVERR <= (err_sel != ERR_NONE);
              PRDATA  <= rsp_data;
            end
`else
            PREADY  <= 1'b1;
            PSLVERR <= (err_sel != ERR_NONE);
            PRDATA  <= rsp_data;
`endif
          end
        end
        ACCESS: begin
          // Completing cycle or master abort: either way back to IDLE.
          if (!PSELx || PREADY) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else begin
`ifdef APB_SLV_WAIT_STATES_EN
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              PREADY  <= 1'b1;
              PSLVERR <= (err_sel != ERR_NONE);
              PRDATA  <= rsp_data;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slv_regfile.sv
// Scoreboard bench for apb_slv_regfile; honours APB_SLV_WAIT_STATES_EN.
module tb_apb_slv_regfile;
  import apb_slv_pkg::*;

`ifdef APB_SLV_WAIT_STATES_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic                      PCLK;
  logic                      PRESET;
  logic                      PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DEF_ADDR_WIDTH-1:0] PADDR;
  logic [DEF_DATA_WIDTH-1:0] PWDATA;
  logic [DEF_STRB_WIDTH-1:0] PSTRB;
  logic [DEF_DATA_WIDTH-1:0] PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  apb_slv_regfile #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (8),
    .DEPTH       (32),
    .RO_BASE     (24),
    .WAIT_CYCLES (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Full transfer; caller sits just after a rising edge. Leaves the bus idle
  // in the cycle after completion, so a following call is back-to-back.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   cyc;
    sb.push_back('{tag: tag, wr: wr, rd: exp_rd, err: exp_err, lat: EXP_WAIT + 1});
    PSELx   = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 1;
    @(negedge PCLK);
    while (!PREADY && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    e = sb.pop_front();
    if (!PREADY) begin
      chk({e.tag, "_timeout"}, 32'(PREADY), 32'd1);
    end else begin
      chk({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
      chk({e.tag, "_err"}, 32'(PSLVERR), 32'(e.err));
      if (!e.wr) chk({e.tag, "_rdata"}, PRDATA, e.rd);
    end
    @(posedge PCLK); #1;
    PSELx   = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #1;
    xfer("rst_rd5", 1'b0, 8'h14, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

    xfer("wr10", 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer("rd10", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    xfer("wr08", 1'b1, 8'h08, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
    xfer("wr08_s5", 1'b1, 8'h08, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
    xfer("rd08", 1'b0, 8'h08, 32'h0, 4'hF, 32'hAA22_CC44, 1'b0);

    xfer("wr10_s0", 1'b1, 8'h10, 32'h0BAD_0BAD, 4'h0, 32'h0, 1'b0);
    xfer("rd10_s0", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    xfer("rd_misal", 1'b0, 8'h02, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer("wr_misal", 1'b1, 8'h11, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer("rd_range", 1'b0, 8'h80, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer("wr_ro", 1'b1, 8'h60, 32'h5555_AAAA, 4'hF, 32'h0, 1'b1);
    xfer("rd_ro", 1'b0, 8'h60, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer("rd10_err", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xfer("wr_last_rw", 1'b1, 8'h5C, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    xfer("rd_last_rw", 1'b0, 8'h5C, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
    xfer("rd_last", 1'b0, 8'h7C, 32'h0, 4'h0, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      xfer("loop_wr", 1'b1, 8'(8'h20 + 4 * i), 32'h1000_0000 + 32'(i * 7), 4'hF, 32'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer("loop_rd", 1'b0, 8'(8'h20 + 4 * i), 32'h0, 4'h0, 32'h1000_0000 + 32'(i * 7), 1'b0);
    end

    // Setup then PENABLE=1 with PSELx already dropped: aborted write.
    xfer("wr04_old", 1'b1, 8'h04, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04;
    PWDATA = 32'h1234_5678; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    xfer("rd04_abort", 1'b0, 8'h04, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // PENABLE high in IDLE must not start a transfer.
    PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("penable_idle", 32'(PREADY), 32'd0);
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;

    // Reset during the first access cycle.
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04;
    PWDATA = 32'h55AA_55AA; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
    chk("midrst_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #1;
    xfer("rd04_rst", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer("rd10_rst", 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slv_regfile.md
# apb_slv_regfile

Parametrised APB4 slave register file with byte strobes, programmable wait states and error signalling on illegal accesses. Next-generation slave for the APB verification environment: a DUT-grade target for the `apb_slv_interfs` agents, generalised in data width, depth and wait timing. Sits behind a single APB requester, one PSELx per instance.

## Interface
- DATA_WIDTH, 32, PRDATA/PWDATA width; 8, 16, 32 or 64.
- ADDR_WIDTH, 8, PADDR width, byte address.
- DEPTH, 32, number of DATA_WIDTH-bit words; DEPTH*DATA_WIDTH/8 ≤ 2**ADDR_WIDTH.
- RO_BASE, 24, first word index that is read-only; RO_BASE ≥ DEPTH means no read-only region.
- WAIT_CYCLES, 2, access-phase wait states when the wait feature is compiled in; 0–15.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PSELx  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte lanes.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; valid only while PREADY=1, 0 otherwise.

## Operation
- Word index = PADDR >> log2(DATA_WIDTH/8). Low offset bits are the byte offset.
- Error conditions, checked in priority order: byte offset ≠ 0 (misaligned); index ≥ DEPTH (out of range); write with index ≥ RO_BASE (read-only).
- On error: no storage update; PSLVERR=1 in the completing cycle; PRDATA=0 for errored reads.
- Write: only lanes with PSTRB[i]=1 are updated. PSTRB=0 is a legal write that changes no data.
- Read: PSTRB is ignored; PRDATA returns the full word.
- FSM states:
  - IDLE → ACCESS when PSELx=1 and PENABLE=0 are sampled. Latch address, direction, data and strobe; load the wait counter.
  - ACCESS: wait counter decrements each cycle. PREADY=1 in the cycle the counter is 0.
  - ACCESS → IDLE after the completing cycle. The write is committed at the PCLK edge that ends the completing cycle.
  - ACCESS → IDLE immediately, with no write, if PSELx=0 is sampled (master abort).
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, every storage word = 0.

## Timing
- Setup phase is cycle T0. With N wait states, PREADY=1 in cycle T1+N; PRDATA and PSLVERR are valid in that same cycle.
- Read data comes from storage contents after any write committed earlier; there is no read-during-write hazard.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted with no idle gap.
- PRESET during ACCESS:
  - The pending write is dropped.
  - Outputs are 0 in the next cycle.
  - Storage is cleared.
- PENABLE=1 while in IDLE (protocol violation) is ignored; no response is generated.

## Configuration
- APB_SLV_WAIT_STATES_EN defined: WAIT_CYCLES wait states are inserted on every transfer.
- Not defined: WAIT_CYCLES is ignored, the wait counter is not built, and PREADY=1 in T1 (zero-wait).
- PSLVERR rules are identical in both builds.

## Structure
- apb_slv_pkg holds:
  - state typedef enum {IDLE, ACCESS};
  - the error-cause enum {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RO};
  - the localparam for strobe width and offset bits.
- Sub-module apb_slv_regbank: DEPTH×DATA_WIDTH storage with byte-lane write enables, a synchronous clear and a combinational read port. The top module holds the FSM, error decode and wait counter.

## Test plan
- Reset: hold PRESET 3 cycles → PREADY=0, PSLVERR=0, PRDATA=0; reading index 5 returns 0x00000000.
- Write 0xDEADBEEF to 0x10, PSTRB=0xF, then read 0x10 → PRDATA=0xDEADBEEF, PSLVERR=0. With the macro and WAIT_CYCLES=2, PREADY rises in T3; without the macro, in T1.
- Write 0xAABBCCDD to 0x08 with PSTRB=0xF, then write 0x11223344 with PSTRB=0x5 → read 0x08 returns 0xAA22CC44.
- Errors, each with PSLVERR=1 and PRDATA=0 where applicable, storage unchanged:
  - read at 0x02 (misaligned);
  - read at 0x80 with DEPTH=32 (out of range);
  - write to 0x60 (index 24, read-only).
- Abort and reset mid-transfer:
  - drop PSELx in the first wait cycle of a write of 0x12345678 to 0x04 → read 0x04 returns the old value;
  - PRESET during a wait cycle → next read of 0x04 returns 0.
